dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
- Data-memory responder: the target end of the memory-stage load/store request interface.
- Accepts one load/store request at a time with a valid/ready handshake.
- Performs byte, halfword or word access on an internal synchronous word array; sub-word stores use read-modify-write.
- Returns one response pulse per request: aligned/sign-extended load data or a store completion, plus an error flag.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width (fixed 32 for op decoding)
DEPTH_LOG2, 10, log2 of array depth in words (default 1024 words)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  responder idle, request accepted when valid&&ready at clock edge
req_we_i  in  1  1=store, 0=load; must equal req_op_i[3]
req_addr_i  in  ADDR_WIDTH  byte address
req_data_i  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
req_op_i  in  4  0=LB 1=LH 2=LW 4=LBU 5=LHU 8=SB 9=SH A=SW, others illegal
resp_valid_o  out  1  single-cycle response pulse
resp_data_o  out  DATA_WIDTH  load result; 0 for stores and errors
resp_err_o  out  1  request rejected, valid only with resp_valid_o

Behaviour:
- Reset (rst_i=0, async): state IDLE, req_ready_o=0 while reset held, resp_valid_o=0, resp_data_o=0, resp_err_o=0. Array contents are not cleared. Any in-flight store is aborted; no array write occurs on or after the reset edge.
- After reset release: req_ready_o=1 exactly when state==IDLE.
- FSM states: IDLE, RD, WR, RESP.
- Request capture: addr, data, op and we are latched at the accept edge; inputs are don't-care afterwards.
- Word index = addr[DEPTH_LOG2+1:2]; upper address bits ignored (wrap-around).
- Error check at accept. Any of the following skips the array entirely: IDLE->RESP, resp_err_o=1, resp_data_o=0, latency 1 cycle.
  - illegal op
  - we != op[3]
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
- Loads: IDLE->RD (array read issued) -> RESP.
  - Byte/half selected by addr[1:0]; sign-extended for LB/LH, zero-extended for LBU/LHU.
  - resp_valid_o high in the 2nd cycle after the accept edge.
- SW: IDLE->WR (full-word write at the next edge) -> RESP. resp_valid_o in the 2nd cycle after accept.
- SB/SH: IDLE->RD->WR -> RESP.
  - WR merges the byte/half into the read word at lane addr[1:0] and writes it back.
  - resp_valid_o in the 3rd cycle after accept.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. No response backpressure. resp_data_o/resp_err_o return to 0 when resp_valid_o=0.
- Back-to-back: req_ready_o rises in the cycle after RESP. Minimum spacing is RESP+1.
- A load following a store to the same word returns the stored data; the write completes before the load's read is issued.
- req_valid_i while not ready: ignored, not queued. The requester must hold it.
- Little-endian lane order: addr[1:0]=0 is bits [7:0].

Test Plan:
- Reset then SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> resp_valid 2 cycles after each accept; load resp_data=0xDEADBEEF, resp_err=0.
- After the above: LB 0x11 -> 0xFFFFFFBE; LBU 0x11 -> 0x000000BE; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- SB 0x13 data=0x12, then LW 0x10 -> store response at accept+3 cycles; load returns 0x12ADBEEF.
- LW 0x12, SH 0x11, op=0x3, and we=1 with op=LW -> each gives resp_err=1, resp_data=0, 1-cycle latency; memory unchanged (LW 0x10 still 0x12ADBEEF).
- SW 0x10 (default DEPTH_LOG2=10) addr=0x1010 data=0x55 -> LW 0x10 returns 0x55 (wrap-around).
- SH 0x20 data=0xABCD accepted, rst_i=0 asserted in the RD cycle -> outputs 0 immediately; after release ready=1 and LW 0x20 returns the pre-existing value (no write).

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store at a time and answers with a single-cycle
// response. Sub-word stores are read-modify-write on a synchronous word array.
`timescale 1ns/1ps

module dmem_resp #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [3:0]            req_op_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  resp_err_o
);

    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [DEPTH_LOG2+1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            op_q;
    logic                  we_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  req_err;
    logic                  accept;

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    wire [DEPTH_LOG2-1:0] word_idx = addr_q[DEPTH_LOG2+1:2];
    wire [1:0]            lane     = addr_q[1:0];

    // Address bits above the array wrap around and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2];

    assign req_ready_o  = rst_i && (state_q == S_IDLE);
    assign accept       = req_valid_i && req_ready_o;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_err_o   = (state_q == S_RESP) && err_q;
    assign resp_data_o  = (state_q == S_RESP && !err_q && !we_q) ? load_data : '0;

    // Rejection is decided from the live request so that errors skip the array entirely.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a missed branch infers a latch.
        req_err = 1'b0;
        case (req_op_i)
            OP_LB, OP_LBU, OP_SB: req_err = 1'b0;
            OP_LH, OP_LHU, OP_SH: req_err = req_addr_i[0];
            OP_LW, OP_SW:         req_err = (req_addr_i[1:0] != 2'b00);
            default:              req_err = 1'b1;
        endcase
        if (req_we_i != req_op_i[3]) req_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                state_d = S_RESP;
                    else if (req_op_i == OP_SW) state_d = S_WR;
                    else                        state_d = S_RD;
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state is always assigned with <=, so every flop samples pre-edge values.
        if (!rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= req_addr_i[DEPTH_LOG2+1:0];
                data_q <= req_data_i;
                op_q   <= req_op_i;
                we_q   <= req_we_i;
                err_q  <= req_err;
            end
        end
    end

    // Lane merge for stores; a full-word store ignores the read word.
    always_comb begin
        wr_data = rd_data_q;
        case (op_q)
            OP_SB:   wr_data[{lane, 3'b000} +: 8]     = data_q[7:0];
            OP_SH:   wr_data[{lane[1], 4'b0000} +: 16] = data_q[15:0];
            default: wr_data = data_q;
        endcase
    end

    always_comb begin
        load_data = '0;
        case (op_q)
            OP_LB:   load_data = {{24{rd_data_q[{lane, 3'b111}]}}, rd_data_q[{lane, 3'b000} +: 8]};
            OP_LBU:  load_data = {24'h0, rd_data_q[{lane, 3'b000} +: 8]};
            OP_LH:   load_data = {{16{rd_data_q[{lane[1], 4'b1111}]}}, rd_data_q[{lane[1], 4'b0000} +: 16]};
            OP_LHU:  load_data = {16'h0, rd_data_q[{lane[1], 4'b0000} +: 16]};
            OP_LW:   load_data = rd_data_q;
            default: load_data = '0;
        endcase
    end

    // NOTE: the array and its read register are deliberately left out of reset so they map onto block RAM.
    // Reset forces IDLE, so a store caught mid-flight never reaches its WR edge.
    always_ff @(posedge clk_i) begin
        if (state_q == S_WR) mem[word_idx] <= wr_data;
        if (state_q == S_RD) rd_data_q <= mem[word_idx];
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: expected responses are queued at accept and
// compared, including latency, when the responder pulses resp_valid_o.
`timescale 1ns/1ps

module tb_dmem_resp;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_op_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;

    dmem_resp dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_op_i     (req_op_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          accept_cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (resp_valid_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_err", {31'b0, resp_err_o}, {31'b0, mon_e.err});
                    check("resp_data", resp_data_o, mon_e.data);
                    check("resp_latency", cyc - mon_e.accept_cyc + 1, mon_e.lat);
                end
            end else if (resp_err_o || resp_data_o != 32'h0) begin
                check("idle_outputs_zero", resp_data_o | {31'b0, resp_err_o}, 32'h0);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int guard = 0;
        @(negedge clk_i);
        while (!req_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        ok = req_ready_o;
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic req(input logic we, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic exp_err,
                       input logic [31:0] exp_data, input int lat);
        exp_t e;
        bit   ok;
        wait_ready(ok);
        if (!ok) return;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_op_i    = op;
        req_addr_i  = addr;
        req_data_i  = data;
        @(posedge clk_i);
        #1;
        e.err        = exp_err;
        e.data       = exp_data;
        e.accept_cyc = cyc;
        e.lat        = lat;
        sb_q.push_back(e);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_data_i  = $urandom;
        req_op_i    = 4'($urandom);
        req_we_i    = 1'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 32'd0);
    endtask

    initial begin
        bit ok;

        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'b0, req_ready_o}, 32'd0);
        check("rst_valid", {31'b0, resp_valid_o}, 32'd0);
        check("rst_data", resp_data_o, 32'h0);
        check("rst_err", {31'b0, resp_err_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        check("post_rst_ready", {31'b0, req_ready_o}, 32'd1);

        // word store/load and sub-word extraction
        req(1'b1, 4'hA, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        req(1'b0, 4'h2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
        req(1'b0, 4'h0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFBE, 2);
        req(1'b0, 4'h4, 32'h11, 32'h0, 1'b0, 32'h000000BE, 2);
        req(1'b0, 4'h1, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 2);
        req(1'b0, 4'h5, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 2);
        req(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 2);
        req(1'b0, 4'h5, 32'h10, 32'h0, 1'b0, 32'h0000BEEF, 2);

        // byte store read-modify-write
        req(1'b1, 4'h8, 32'h13, 32'hFFFFFF12, 1'b0, 32'h0, 3);
        req(1'b0, 4'h2, 32'h10, 32'h0, 1'b0, 32'h12ADBEEF, 2);

        // rejected requests leave memory untouched
        req(1'b0, 4'h2, 32'h12, 32'h0, 1'b1, 32'h0, 1);
        req(1'b1, 4'h9, 32'h11, 32'h5555, 1'b1, 32'h0, 1);
        req(1'b0, 4'h3, 32'h10, 32'h0, 1'b1, 32'h0, 1);
        req(1'b1, 4'h2, 32'h10, 32'h0, 1'b1, 32'h0, 1);
        req(1'b0, 4'h8, 32'h10, 32'h77, 1'b1, 32'h0, 1);
        req(1'b1, 4'hA, 32'h12, 32'h0, 1'b1, 32'h0, 1);
        req(1'b0, 4'h2, 32'h10, 32'h0, 1'b0, 32'h12ADBEEF, 2);

        // halfword store into upper lane
        req(1'b1, 4'hA, 32'h14, 32'h00000000, 1'b0, 32'h0, 2);
        req(1'b1, 4'h9, 32'h16, 32'h7777ABCD, 1'b0, 32'h0, 3);
        req(1'b0, 4'h2, 32'h14, 32'h0, 1'b0, 32'hABCD0000, 2);
        req(1'b0, 4'h0, 32'h16, 32'h0, 1'b0, 32'hFFFFFFCD, 2);

        // upper address bits wrap onto the same word
        req(1'b1, 4'hA, 32'h1010, 32'h00000055, 1'b0, 32'h0, 2);
        req(1'b0, 4'h2, 32'h10, 32'h0, 1'b0, 32'h00000055, 2);

        // reset during the read phase of a halfword store aborts it
        req(1'b1, 4'hA, 32'h20, 32'h11223344, 1'b0, 32'h0, 2);
        req(1'b0, 4'h2, 32'h20, 32'h0, 1'b0, 32'h11223344, 2);
        drain();
        wait_ready(ok);
        if (ok) begin
            req_valid_i = 1'b1;
            req_we_i    = 1'b1;
            req_op_i    = 4'h9;
            req_addr_i  = 32'h20;
            req_data_i  = 32'h0000ABCD;
            @(posedge clk_i);
            #1;
            req_valid_i = 1'b0;
            rst_i = 1'b0;
            #1;
            check("midrst_valid", {31'b0, resp_valid_o}, 32'd0);
            check("midrst_ready", {31'b0, req_ready_o}, 32'd0);
            check("midrst_data", resp_data_o | {31'b0, resp_err_o}, 32'h0);
            repeat (3) @(negedge clk_i);
            rst_i = 1'b1;
            #1;
            check("midrst_release_ready", {31'b0, req_ready_o}, 32'd1);
        end
        req(1'b0, 4'h2, 32'h20, 32'h0, 1'b0, 32'h11223344, 2);
        req(1'b0, 4'h2, 32'h10, 32'h0, 1'b0, 32'h00000055, 2);

        drain();
        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
